leela_sprite_overlay: RTL



---
 rtl/leela_sprite_pkg.sv | 21 ++
 rtl/leela_sprite_window.sv | 25 ++
 rtl/leela_sprite_overlay.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/leela_sprite_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leela_sprite_pkg : sprite geometry constants and fetch FSM state type
// Rev 1.0
// ----------------------------------------------------------------------------
package leela_sprite_pkg;

  localparam int SPR_W     = 32;
  localparam int SPR_H     = 32;
  localparam int SPR_ADR_W = 6;
  localparam int SPR_IDX_W = $clog2(SPR_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } spr_state_e;

endpackage
`default_nettype wire

// File: rtl/leela_sprite_window.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leela_sprite_window : combinational 32-wide range check of coord vs origin
// Rev 1.0
// ----------------------------------------------------------------------------
module leela_sprite_window
  import leela_sprite_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic [CNT_W-1:0]     i_coord,
  input  logic [CNT_W-1:0]     i_origin,
  output logic                 o_inside,
  output logic [SPR_IDX_W-1:0] o_offset
);

  // One extra bit so a coord left of / above the origin shows up as a borrow.
  logic [CNT_W:0] w_diff;

  assign w_diff   = {1'b0, i_coord} - {1'b0, i_origin};
  assign o_inside = ~w_diff[CNT_W] && (w_diff[CNT_W-1:0] < CNT_W'(SPR_W));
  assign o_offset = w_diff[SPR_IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/leela_sprite_overlay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leela_sprite_overlay : fetches one 1-bpp sprite row per line and overlays it
// on the pixel stream. Define LEELA_SPRITE_XOR_EN for inverted-pixel sprites.
// Rev 1.0
// ----------------------------------------------------------------------------
module leela_sprite_overlay
  import leela_sprite_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_start_i,
  input  logic [CNT_W-1:0]     line_y_i,
  input  logic                 pix_valid_i,
  input  logic [PIX_W-1:0]     pix_dat_i,
  input  logic                 spr_en_i,
  input  logic                 spr_sel_i,
  input  logic [CNT_W-1:0]     spr_x_i,
  input  logic [CNT_W-1:0]     spr_y_i,
  input  logic [PIX_W-1:0]     spr_color_i,
  output logic [SPR_ADR_W-1:0] rom_adr_o,
  input  logic [SPR_W-1:0]     rom_dat_i,
  output logic                 pix_valid_o,
  output logic [PIX_W-1:0]     pix_dat_o
);

  localparam logic [CNT_W-1:0] C_XCNT_MAX = '1;

  spr_state_e           r_state;
  spr_state_e           w_state_nxt;
  logic                 w_load_row;

  logic                 w_y_inside;
  logic                 w_y_hit;
  logic [SPR_IDX_W-1:0] w_y_off;
  logic                 w_x_inside;
  logic [SPR_IDX_W-1:0] w_x_off;
  logic [SPR_IDX_W-1:0] w_bit_idx;
  logic                 w_bit;
  logic                 w_overlay;
  logic [PIX_W-1:0]     w_spr_pix;

  logic                 r_hit;
  logic [SPR_W-1:0]     r_row;
  logic [CNT_W-1:0]     r_xcnt;
  logic [CNT_W-1:0]     r_spr_x;
  logic [SPR_ADR_W-1:0] r_rom_adr;
  logic                 r_pix_valid;
  logic [PIX_W-1:0]     r_pix_dat;

  leela_sprite_window #(.CNT_W(CNT_W)) u_win_y (
    .i_coord  (line_y_i),
    .i_origin (spr_y_i),
    .o_inside (w_y_inside),
    .o_offset (w_y_off)
  );

  leela_sprite_window #(.CNT_W(CNT_W)) u_win_x (
    .i_coord  (r_xcnt),
    .i_origin (r_spr_x),
    .o_inside (w_x_inside),
    .o_offset (w_x_off)
  );

  assign w_y_hit   = w_y_inside & spr_en_i;
  // MSB of the ROM row is the leftmost sprite pixel.
  assign w_bit_idx = SPR_IDX_W'(SPR_W - 1) - w_x_off;
  assign w_bit     = r_row[w_bit_idx];
  // A pixel sharing its cycle with line_start belongs to the old line: never overlay it.
  assign w_overlay = w_x_inside & w_bit & ~line_start_i;

`ifdef LEELA_SPRITE_XOR_EN
  logic [PIX_W-1:0] w_unused_color;
  assign w_unused_color = spr_color_i;
  assign w_spr_pix      = pix_dat_i ^ {PIX_W{1'b1}};
`else
  logic [PIX_W-1:0] r_color;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= '0;
    end else if (line_start_i) begin
      r_color <= spr_color_i;
    end
  end
  assign w_spr_pix = r_color;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_row  = 1'b0;
    case (r_state)
      IDLE:    if (line_start_i) w_state_nxt = ADDR;
      ADDR:    w_state_nxt = line_start_i ? ADDR : WAIT;
      WAIT: begin
        w_state_nxt = line_start_i ? ADDR : ACTIVE;
        w_load_row  = ~line_start_i;
      end
      ACTIVE:  if (line_start_i) w_state_nxt = ADDR;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Row fetch: address on line_start, data captured once the ROM output is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_adr <= '0;
      r_hit     <= 1'b0;
      r_row     <= '0;
      r_spr_x   <= '0;
    end else if (line_start_i) begin
      r_rom_adr <= w_y_hit ? {spr_sel_i, w_y_off} : '0;
      r_hit     <= w_y_hit;
      r_row     <= '0;
      r_spr_x   <= spr_x_i;
    end else if (w_load_row) begin
      r_row     <= r_hit ? rom_dat_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xcnt <= '0;
    end else if (line_start_i) begin
      r_xcnt <= '0;
    end else if (pix_valid_i && (r_xcnt != C_XCNT_MAX)) begin
      r_xcnt <= r_xcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_valid <= 1'b0;
      r_pix_dat   <= '0;
    end else begin
      r_pix_valid <= pix_valid_i;
      if (pix_valid_i) begin
        r_pix_dat <= w_overlay ? w_spr_pix : pix_dat_i;
      end
    end
  end

  assign rom_adr_o   = r_rom_adr;
  assign pix_valid_o = r_pix_valid;
  assign pix_dat_o   = r_pix_dat;

endmodule
`default_nettype wire
